// File: rtl/comm_proto_pkg.sv
// Shared definitions for the serial command protocol: message types,
// frame limits and the state encodings of the reply framer.
package comm_proto_pkg;

  localparam logic [7:0] MSG_RESERVED  = 8'h00;
  localparam logic [7:0] MSG_SYS_RESET = 8'h01;
  localparam logic [7:0] MSG_STEP      = 8'h02;
  localparam logic [7:0] MSG_RANGE     = 8'h03;
  localparam logic [7:0] MSG_BASE_ADDR = 8'h04;
  localparam logic [7:0] MSG_RAM_DATA  = 8'h05;

  localparam logic [7:0] MAX_FRAME_LEN  = 8'd255;
  localparam int         BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_TYPE  = 3'd2,
    ST_FETCH = 3'd3,
    ST_HI    = 3'd4,
    ST_LO    = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_e;

  typedef enum logic [1:0] {
    BS_WAIT  = 2'd0,
    BS_SEND  = 2'd1,
    BS_GUARD = 2'd2
  } byte_state_e;

  // Length counts the msgType byte plus payload; 1 + 2*127 = 255 still fits.
  function automatic logic [7:0] frame_len(input logic src, input logic [6:0] count);
    if (src)
      frame_len = {count, 1'b1};
    else
      frame_len = 8'(1 + BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/comm_tx_byte.sv
// Single-byte handoff to the UART transmitter: holds one byte, strobes
// send_data when the UART is idle, then ignores busy for one guard cycle.
module comm_tx_byte
  import comm_proto_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  output logic       o_byte_ready,
  output logic       o_pending,
  input  logic       i_busy,
  output logic [7:0] o_tx_data,
  output logic       o_send_data
);

  byte_state_e r_state;
  logic [7:0]  r_buf;
  logic [7:0]  r_last;
  logic        w_send;
  logic        w_accept;

  // The strobe is gated by the live busy level so a pulse can never land on
  // a busy UART, even one that raises busy a cycle late.
  assign w_send       = (r_state == BS_SEND) && !i_busy;
  assign o_send_data  = w_send;
  assign o_byte_ready = (r_state == BS_GUARD) || ((r_state == BS_WAIT) && !i_busy);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign o_pending    = (r_state == BS_SEND);

  // tx_data switches to the new byte exactly in its send cycle and then holds.
  assign o_tx_data = w_send ? r_buf : r_last;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= BS_WAIT;
      r_buf   <= 8'h00;
      r_last  <= 8'h00;
    end else begin
      case (r_state)
        BS_WAIT: begin
          if (w_accept) begin
            r_buf   <= i_byte_data;
            r_state <= BS_SEND;
          end
        end
        BS_SEND: begin
          if (w_send) begin
            r_last  <= r_buf;
            r_state <= BS_GUARD;
          end
        end
        BS_GUARD: begin
          if (w_accept) begin
            r_buf   <= i_byte_data;
            r_state <= BS_SEND;
          end else begin
            r_state <= BS_WAIT;
          end
        end
        default: r_state <= BS_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/comm_tx_framer.sv
// Reply framer: builds length/type/payload frames from an immediate value or
// a sample-RAM block and feeds them one byte at a time to the UART.
module comm_tx_framer
  import comm_proto_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 16,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_type,
  input  logic                    req_src,
  input  logic [OUTPUT_WIDTH-1:0] req_value,
  input  logic [ADDR_WIDTH-1:0]   req_base,
  input  logic [6:0]              req_count,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_en,
  input  logic [OUTPUT_WIDTH-1:0] rd_data,
  output logic [7:0]              tx_data,
  output logic                    send_data,
  input  logic                    busy,
  output logic                    frame_done
);

  tx_state_e               r_state;
  logic [7:0]              r_type;
  logic                    r_src;
  logic [OUTPUT_WIDTH-1:0] r_word;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [6:0]              r_count;
  logic [6:0]              r_index;
  logic                    r_fetch_wait;
  logic                    r_rd_en;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic                    r_frame_done;

  logic                    w_byte_valid;
  logic [7:0]              w_byte_data;
  logic                    w_byte_ready;
  logic                    w_pending;
  logic [7:0]              w_index_next;
  logic                    w_more_words;

  assign req_ready    = (r_state == ST_IDLE);
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign frame_done   = r_frame_done;
  assign w_index_next = {1'b0, r_index} + 8'd1;
  assign w_more_words = r_src && (w_index_next < {1'b0, r_count});

  always_comb begin
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    case (r_state)
      ST_LEN: begin
        w_byte_valid = 1'b1;
        w_byte_data  = frame_len(r_src, r_count);
      end
      ST_TYPE: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_type;
      end
      ST_HI: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_word[OUTPUT_WIDTH-1 -: 8];
      end
      ST_LO: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_word[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_type       <= 8'h00;
      r_src        <= 1'b0;
      r_word       <= '0;
      r_base       <= '0;
      r_count      <= 7'd0;
      r_index      <= 7'd0;
      r_fetch_wait <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_type  <= req_type;
            r_src   <= req_src;
            r_word  <= req_value;
            r_base  <= req_base;
            r_count <= req_count;
            r_index <= 7'd0;
            r_state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_byte_ready) r_state <= ST_TYPE;
        end
        ST_TYPE: begin
          if (w_byte_ready) begin
            if (!r_src) begin
              r_state <= ST_HI;
            end else if (r_count == 7'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_base + ADDR_WIDTH'(r_index);
              r_state   <= ST_FETCH;
            end
          end
        end
        // Phase 0 carries the read strobe; the RAM answers during phase 1.
        ST_FETCH: begin
          if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_fetch_wait <= 1'b0;
            r_word       <= rd_data;
            r_state      <= ST_HI;
          end
        end
        ST_HI: begin
          if (w_byte_ready) r_state <= ST_LO;
        end
        ST_LO: begin
          if (w_byte_ready) begin
            if (w_more_words) begin
              r_index   <= w_index_next[6:0];
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_base + ADDR_WIDTH'(w_index_next[6:0]);
              r_state   <= ST_FETCH;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        // Hold until the final byte has actually been strobed into the UART.
        ST_DONE: begin
          if (!w_pending) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  comm_tx_byte u_tx_byte (
    .clk          (clk),
    .i_rst_n      (reset),
    .i_byte_valid (w_byte_valid),
    .i_byte_data  (w_byte_data),
    .o_byte_ready (w_byte_ready),
    .o_pending    (w_pending),
    .i_busy       (busy),
    .o_tx_data    (tx_data),
    .o_send_data  (send_data)
  );

endmodule

// File: tb/tb_comm_tx_framer.sv
// Randomized bench for comm_tx_framer: a UART/RAM model drives the DUT and a
// frame-level reference model predicts every byte and RAM address.
module tb_comm_tx_framer;
  import comm_proto_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_type;
  logic        req_src;
  logic [15:0] req_value;
  logic [11:0] req_base;
  logic [6:0]  req_count;
  logic [11:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data = 16'h0000;
  logic [7:0]  tx_data;
  logic        send_data;
  logic        busy = 1'b0;
  logic        frame_done;

  always #5 clk = ~clk;

  comm_tx_framer #(.OUTPUT_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_src(req_src), .req_value(req_value),
    .req_base(req_base), .req_count(req_count), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data), .tx_data(tx_data),
    .send_data(send_data), .busy(busy), .frame_done(frame_done)
  );

  logic [15:0] mem [0:4095];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // UART model: busy is high for busy_len cycles starting busy_dly cycles after a send.
  int cyc = 0;
  int busy_dly = 1;
  int busy_len = 0;
  int busy_from = -10;
  int busy_to = -20;
  bit force_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    busy = force_busy || (cyc >= busy_from && cyc <= busy_to);
  end

  logic [7:0]  exp_q[$];
  logic [11:0] exp_a[$];
  logic [7:0]  obs_q[$];
  logic [11:0] obs_a[$];
  int done_cnt = 0;
  int last_send = -1;
  bit have_last = 1'b0;
  logic [7:0] last_byte = 8'h00;
  bit strict_sp = 1'b0;
  int strict_start = 0;
  int obs_base = 0, addr_base = 0, done_base = 0;

  always @(negedge clk) begin
    if (!reset) begin
      have_last = 1'b0;
    end else if (send_data) begin
      check_val("send_while_busy", busy, 0);
      if (last_send >= 0) begin
        if (strict_sp && last_send >= strict_start)
          check_val("spacing", cyc - last_send, 2);
        else
          check_val("spacing_min", (cyc - last_send) >= 2, 1);
      end
      last_send = cyc;
      obs_q.push_back(tx_data);
      last_byte = tx_data;
      have_last = 1'b1;
      if (busy_len > 0) begin
        busy_from = cyc + busy_dly;
        busy_to   = busy_from + busy_len - 1;
      end
    end else if (have_last) begin
      check_val("tx_hold", tx_data, last_byte);
    end
    if (rd_en) obs_a.push_back(rd_addr);
    if (frame_done) done_cnt++;
  end

  // Reference model: the frame as a plain byte list built from the protocol rules.
  task automatic expect_frame(input bit src, input logic [7:0] typ, input logic [15:0] val,
                              input logic [11:0] base, input int count);
    logic [11:0] a;
    logic [15:0] w;
    exp_q.push_back(src ? 8'(1 + 2 * count) : 8'd3);
    exp_q.push_back(typ);
    if (!src) begin
      exp_q.push_back(val[15:8]);
      exp_q.push_back(val[7:0]);
    end else begin
      for (int i = 0; i < count; i++) begin
        a = 12'((int'(base) + i) % 4096);
        w = mem[a];
        exp_a.push_back(a);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
  endtask

  task automatic issue(input bit src, input logic [7:0] typ, input logic [15:0] val,
                       input logic [11:0] base, input int count);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 5000) begin @(negedge clk); n++; end
    if (!req_ready) check_val("issue_timeout", 0, 1);
    req_src = src; req_type = typ; req_value = val; req_base = base;
    req_count = 7'(count); req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_val("ready_drop", req_ready, 0);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while ((done_cnt - done_base) < n && k < 20000) begin @(negedge clk); k++; end
    if ((done_cnt - done_base) < n) check_val("done_timeout", done_cnt - done_base, n);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int n_done);
    int nb, na;
    nb = obs_q.size() - obs_base;
    na = obs_a.size() - addr_base;
    check_val({tag, "_nbytes"}, nb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i),
                (i < nb) ? 32'(obs_q[obs_base + i]) : 32'h1FF, exp_q[i]);
    check_val({tag, "_naddr"}, na, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      check_val($sformatf("%s_addr%0d", tag, i),
                (i < na) ? 32'(obs_a[addr_base + i]) : 32'h1FFFF, exp_a[i]);
    check_val({tag, "_done"}, done_cnt - done_base, n_done);
    check_val({tag, "_ready"}, req_ready, 1);
    obs_base = obs_q.size(); addr_base = obs_a.size(); done_base = done_cnt;
    exp_q.delete(); exp_a.delete();
  endtask

  task automatic run(input string tag, input bit src, input logic [7:0] typ,
                     input logic [15:0] val, input logic [11:0] base, input int count);
    expect_frame(src, typ, val, base, count);
    issue(src, typ, val, base, count);
    wait_done(1);
    check_frame(tag, 1);
  endtask

  initial begin
    int k;
    reset = 1'b0; req_valid = 1'b0; req_type = 8'h00; req_src = 1'b0;
    req_value = 16'h0000; req_base = 12'h000; req_count = 7'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[12'h010] = 16'hAAAA; mem[12'h011] = 16'h1234; mem[12'h012] = 16'hBEEF;
    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_send", send_data, 0);
    check_val("rst_done", frame_done, 0);
    reset = 1'b1;

    busy_dly = 1; busy_len = 10;
    run("imm", 1'b0, MSG_STEP, 16'h0123, 12'h000, 0);
    busy_len = 3;
    run("ram", 1'b1, MSG_RAM_DATA, 16'h0000, 12'h010, 3);
    run("wrap", 1'b1, MSG_RAM_DATA, 16'h0000, 12'hFFE, 3);
    busy_len = 1;
    run("max", 1'b1, MSG_RAM_DATA, 16'h0000, 12'h100, 127);
    run("zero", 1'b1, MSG_RAM_DATA, 16'h0000, 12'h200, 0);
    busy_dly = 2; busy_len = 3;
    run("late", 1'b1, MSG_RAM_DATA, 16'h0000, 12'h345, 4);
    run("late_imm", 1'b0, MSG_RANGE, 16'h5AC3, 12'h000, 0);

    busy_len = 0; strict_sp = 1'b1; strict_start = cyc;
    run("nobusy", 1'b0, MSG_RANGE, 16'hBEEF, 12'h000, 0);
    strict_sp = 1'b0;

    // Request accepted while busy is stuck high; no byte may go out until it drops.
    force_busy = 1'b1;
    expect_frame(1'b0, MSG_BASE_ADDR, 16'h0F0E, 12'h000, 0);
    issue(1'b0, MSG_BASE_ADDR, 16'h0F0E, 12'h000, 0);
    repeat (20) @(negedge clk);
    check_val("idle_busy_nosend", obs_q.size() - obs_base, 0);
    force_busy = 1'b0;
    wait_done(1);
    check_frame("idle_busy", 1);

    // Second request held valid during an active frame.
    busy_dly = 1; busy_len = 4;
    expect_frame(1'b0, MSG_BASE_ADDR, 16'h1357, 12'h000, 0);
    expect_frame(1'b1, MSG_RAM_DATA, 16'h0000, 12'h7F0, 2);
    issue(1'b0, MSG_BASE_ADDR, 16'h1357, 12'h000, 0);
    req_src = 1'b1; req_type = MSG_RAM_DATA; req_value = 16'h0000;
    req_base = 12'h7F0; req_count = 7'd2; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 5000) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_val("held_after_done", done_cnt - done_base, 1);
    wait_done(2);
    check_frame("held", 2);

    // Reset asserted during the 4th byte of a count=3 frame.
    busy_dly = 1; busy_len = 2;
    expect_frame(1'b1, MSG_RAM_DATA, 16'h0000, 12'h010, 3);
    issue(1'b1, MSG_RAM_DATA, 16'h0000, 12'h010, 3);
    k = 0;
    while ((obs_q.size() - obs_base) < 4 && k < 2000) begin @(negedge clk); k++; end
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_send", send_data, 0);
    check_val("mid_rst_ready", req_ready, 1);
    check_val("mid_rst_rd_en", rd_en, 0);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("mid_rst_byte%0d", i),
                (obs_base + i < obs_q.size()) ? 32'(obs_q[obs_base + i]) : 32'h1FF, exp_q[i]);
    @(posedge clk);
    #1 reset = 1'b1;
    obs_base = obs_q.size(); addr_base = obs_a.size(); done_base = done_cnt;
    exp_q.delete(); exp_a.delete();
    run("after_rst", 1'b0, MSG_STEP, 16'hA55A, 12'h000, 0);

    for (int t = 0; t < 10; t++) begin
      busy_dly = int'($urandom_range(1, 2));
      busy_len = int'($urandom_range(0, 5));
      run($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
          12'($urandom), int'($urandom_range(0, 24)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
